avm_ocm_block_reader: RTL and testbench

AVM_OCM_BLOCK_READER -- requirements
Module: avm_ocm_block_reader

---
 rtl/hram_sys_pkg.sv | 16 +
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/avm_ocm_block_reader.sv | 152 +++++++++++++++
 tb/tb_avm_ocm_block_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hram_sys_pkg.sv
// rtl/hram_sys_pkg.sv - shared state encoding and default widths for the hram subsystem
package hram_sys_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 11;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } rd_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo_fwft #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A pop frees the slot at the same edge, so push is accepted when full if popping.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/avm_ocm_block_reader.sv
// rtl/avm_ocm_block_reader.sv - reads a block of words from on-chip memory into a stream
module avm_ocm_block_reader
    import hram_sys_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);
    localparam int SR_W  = READ_LATENCY + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  ONE_L     = (ADDR_W+1)'(1);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d, issued_q, issued_d, cap_cnt_q, cap_cnt_d;
    logic [SR_W-1:0]   vld_sr_q, vld_sr_d;
    logic              cs_q, cs_d, busy_q, busy_d, done_q, done_d;
    logic [OCC_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, push, pop, can_issue, cap_last;
    logic [DATA_W:0]   head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < SR_W; i++) begin
            inflight = inflight + OCC_W'(vld_sr_q[i]);
        end
    end

    // Bit 0 mirrors the registered chipselect; the top bit marks readdata valid this cycle.
    assign push      = vld_sr_q[READ_LATENCY];
    assign pop       = ~fifo_empty & out_ready;
    assign cap_last  = (cap_cnt_q == len_q - ONE_L);
    assign can_issue = (state_q == ISSUE) && (issued_q != len_q) &&
                       ((OCC_W'(fifo_count) + inflight) < DEPTH_OCC);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        issued_d  = issued_q;
        cap_cnt_d = cap_cnt_q;
        addr_d    = addr_q;
        cs_d      = 1'b0;
        vld_sr_d  = {vld_sr_q[SR_W-2:0], can_issue};
        if (push) begin
            cap_cnt_d = cap_cnt_q + ONE_L;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    len_d     = length;
                    issued_d  = '0;
                    cap_cnt_d = '0;
                    state_d   = (length == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    cs_d     = 1'b1;
                    addr_d   = base_q + issued_q[ADDR_W-1:0];
                    issued_d = issued_q + ONE_L;
                end else if (issued_q == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0 && fifo_count == '0 && !push && !pop) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            cap_cnt_q <= '0;
            addr_q    <= '0;
            vld_sr_q  <= '0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            cap_cnt_q <= cap_cnt_d;
            addr_q    <= addr_d;
            vld_sr_q  <= vld_sr_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cap_last, avm_readdata}),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = 1'b0;
    assign avm_byteenable = '1;
    assign avm_clken      = 1'b1;
    assign out_data       = head[DATA_W-1:0];
    assign out_valid      = ~fifo_empty;
    assign out_last       = ~fifo_empty & head[DATA_W];

endmodule

// File: tb/tb_avm_ocm_block_reader.sv
// tb/tb_avm_ocm_block_reader.sv - bench for avm_ocm_block_reader at read latency 1 and 2
module tb_avm_ocm_block_reader;
    localparam int DW = 16;
    localparam int AW = 11;
    localparam int DEPTH = 4;

    typedef logic [DW:0] word_t;
    typedef word_t word_q_t[$];
    typedef logic [AW-1:0] addr_q_t[$];
    typedef struct {
        logic [AW-1:0] base;
        int            len;
        int            mode;
        bit            dbl;
        logic [DW-1:0] exp_last;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic busy_a, done_a, cs_a, wr_a, clken_a, ov_a, ol_a, rdy_a = 1'b1;
    logic busy_b, done_b, cs_b, wr_b, clken_b, ov_b, ol_b, rdy_b = 1'b1;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW/8-1:0] be_a, be_b;
    logic [DW-1:0] rd_a, rd_b, rd_b1, od_a, od_b;
    int cyc = 0;
    int n_err = 0, n_chk = 0;

    word_q_t got_a, got_b;
    addr_q_t iss_a, iss_b;
    int tcyc_a[$];
    int done_cnt_a, done_cnt_b, busy_cnt_a, busy_cnt_b, first_v_a, first_v_b;
    int n_iss_a, n_iss_b, n_del_a, n_del_b;
    bit hold_a, hold_b;
    logic [DW-1:0] hd_a, hd_b;

    avm_ocm_block_reader #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy_a), .done(done_a), .avm_address(addr_a), .avm_chipselect(cs_a),
        .avm_write(wr_a), .avm_byteenable(be_a), .avm_clken(clken_a), .avm_readdata(rd_a),
        .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a), .out_last(ol_a));

    avm_ocm_block_reader #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy_b), .done(done_b), .avm_address(addr_b), .avm_chipselect(cs_b),
        .avm_write(wr_b), .avm_byteenable(be_b), .avm_clken(clken_b), .avm_readdata(rd_b),
        .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b), .out_last(ol_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory holds word = address; latency 1 for A, 2 for B.
    always @(posedge clk) rd_a <= DW'(addr_a);
    always @(posedge clk) begin
        rd_b1 <= DW'(addr_b);
        rd_b  <= rd_b1;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            hold_a = 1'b0; n_iss_a = 0; n_del_a = 0;
        end else begin
            if (hold_a) begin
                chk("A stable valid", 32'(ov_a), 32'(1));
                chk("A stable data", 32'(od_a), 32'(hd_a));
            end
            if (cs_a) begin
                iss_a.push_back(addr_a); n_iss_a++;
                chk("A buffered+inflight bound", 32'(n_iss_a - n_del_a <= DEPTH), 32'(1));
            end
            if (ov_a && first_v_a < 0) first_v_a = cyc;
            if (ov_a && rdy_a) begin
                got_a.push_back({ol_a, od_a}); tcyc_a.push_back(cyc); n_del_a++;
            end
            if (done_a) done_cnt_a++;
            if (busy_a) busy_cnt_a++;
            hold_a = ov_a && !rdy_a; hd_a = od_a;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold_b = 1'b0; n_iss_b = 0; n_del_b = 0;
        end else begin
            if (hold_b) begin
                chk("B stable valid", 32'(ov_b), 32'(1));
                chk("B stable data", 32'(od_b), 32'(hd_b));
            end
            if (cs_b) begin
                iss_b.push_back(addr_b); n_iss_b++;
                chk("B buffered+inflight bound", 32'(n_iss_b - n_del_b <= DEPTH), 32'(1));
            end
            if (ov_b && first_v_b < 0) first_v_b = cyc;
            if (ov_b && rdy_b) begin
                got_b.push_back({ol_b, od_b}); n_del_b++;
            end
            if (done_b) done_cnt_b++;
            if (busy_b) busy_cnt_b++;
            hold_b = ov_b && !rdy_b; hd_b = od_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void set_ready(input int mode, input int el);
        case (mode)
            0: begin rdy_a = 1'b1; rdy_b = 1'b1; end
            1: begin rdy_a = 1'($urandom_range(0, 1)); rdy_b = 1'($urandom_range(0, 1)); end
            default: begin rdy_a = (el >= 20); rdy_b = (el >= 20); end
        endcase
    endfunction

    function automatic void clear_logs();
        got_a.delete(); got_b.delete(); iss_a.delete(); iss_b.delete(); tcyc_a.delete();
        done_cnt_a = 0; done_cnt_b = 0; busy_cnt_a = 0; busy_cnt_b = 0;
        first_v_a = -1; first_v_b = -1;
    endfunction

    function automatic void check_seq(input string nm, input word_q_t g, input addr_q_t is,
                                      input logic [AW-1:0] base, input int len);
        int bad_o, bad_i;
        logic [AW-1:0] a;
        word_t e;
        bad_o = len; bad_i = len;
        chk({nm, " issue count"}, 32'(is.size()), 32'(len));
        chk({nm, " word count"}, 32'(g.size()), 32'(len));
        for (int i = len - 1; i >= 0; i--) begin
            a = base + AW'(i);
            e = {(i == len - 1), DW'(a)};
            if (i >= g.size() || g[i] !== e) bad_o = i;
            if (i >= is.size() || is[i] !== a) bad_i = i;
        end
        chk({nm, " word sequence first bad index"}, 32'(bad_o), 32'(len));
        chk({nm, " address sequence first bad index"}, 32'(bad_i), 32'(len));
    endfunction

    function automatic void check_idle(input string nm);
        chk({nm, " A busy"}, 32'(busy_a), 32'(0));
        chk({nm, " A done"}, 32'(done_a), 32'(0));
        chk({nm, " A chipselect"}, 32'(cs_a), 32'(0));
        chk({nm, " A out_valid"}, 32'(ov_a), 32'(0));
        chk({nm, " A out_last"}, 32'(ol_a), 32'(0));
        chk({nm, " A address"}, 32'(addr_a), 32'(0));
        chk({nm, " B busy"}, 32'(busy_b), 32'(0));
        chk({nm, " B chipselect"}, 32'(cs_b), 32'(0));
        chk({nm, " B out_valid"}, 32'(ov_b), 32'(0));
        chk({nm, " B out_last"}, 32'(ol_b), 32'(0));
        chk({nm, " B address"}, 32'(addr_b), 32'(0));
        chk({nm, " tie-offs"}, 32'({wr_a, be_a, clken_a, wr_b, be_b, clken_b}), 32'(8'b0111_0111));
    endfunction

    task automatic run_block(input vec_t v);
        int sc, budget;
        clear_logs();
        set_ready(v.mode, 0);
        base_addr = v.base; length = (AW+1)'(v.len); start = 1'b1;
        tick();
        start = 1'b0; sc = cyc;
        budget = 4 * v.len + 200;
        for (int k = 0; k < budget && !(done_cnt_a > 0 && done_cnt_b > 0); k++) begin
            if (v.dbl && k == 2) begin
                base_addr = 11'h500; length = 12'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            set_ready(v.mode, cyc - sc);
            tick();
        end
        start = 1'b0;
        chk("done within budget", 32'(done_cnt_a > 0 && done_cnt_b > 0), 32'(1));
        repeat (4) tick();
        chk("A done pulses", 32'(done_cnt_a), 32'(1));
        chk("B done pulses", 32'(done_cnt_b), 32'(1));
        check_seq("A", got_a, iss_a, v.base, v.len);
        check_seq("B", got_b, iss_b, v.base, v.len);
        if (v.len == 0) begin
            chk("A busy cycles for empty block", 32'(busy_cnt_a), 32'(1));
            chk("B busy cycles for empty block", 32'(busy_cnt_b), 32'(1));
        end else begin
            chk("A last word data", 32'(got_a.size() > 0 ? got_a[$] : '0), 32'({1'b1, v.exp_last}));
            chk("A start-to-valid latency", 32'(first_v_a - sc), 32'(3));
            chk("B start-to-valid latency", 32'(first_v_b - sc), 32'(4));
            if (v.mode == 0 && tcyc_a.size() > 0)
                chk("A back-to-back span", 32'(tcyc_a[$] - tcyc_a[0]), 32'(v.len - 1));
        end
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        bit reached;
        tbl[0] = '{11'h010,    8, 0, 1'b0, 16'h0017};
        tbl[1] = '{11'h7FE,    4, 0, 1'b0, 16'h0001};
        tbl[2] = '{11'h020,    8, 2, 1'b0, 16'h0027};
        tbl[3] = '{11'h100,    0, 0, 1'b0, 16'h0000};
        tbl[4] = '{11'h300,    6, 0, 1'b1, 16'h0305};
        tbl[5] = '{11'h7F0, 2048, 0, 1'b0, 16'h07EF};
        tbl[6] = '{11'h005,    1, 0, 1'b0, 16'h0005};
        tbl[7] = '{11'h123,   13, 1, 1'b0, 16'h012F};

        reset = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_block(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v.base = AW'($urandom);
            v.len = int'($urandom_range(1, 40));
            v.mode = 1;
            v.dbl = 1'b0;
            v.exp_last = DW'(AW'(v.base + AW'(v.len - 1)));
            run_block(v);
        end

        // Reset in the middle of a block, then a clean block afterwards.
        clear_logs();
        set_ready(0, 0);
        base_addr = 11'h040; length = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 50 && !reached; k++) begin
            tick();
            reached = (got_a.size() >= 3);
        end
        chk("three words before reset", 32'(reached), 32'(1));
        reset = 1'b1;
        tick();
        check_idle("mid-transfer reset");
        reset = 1'b0;
        clear_logs();
        repeat (6) tick();
        chk("A words after reset", 32'(got_a.size()), 32'(0));
        chk("B words after reset", 32'(got_b.size()), 32'(0));
        chk("reads after reset", 32'(iss_a.size() + iss_b.size()), 32'(0));
        chk("busy after reset", 32'(busy_cnt_a + busy_cnt_b), 32'(0));
        v = '{11'h050, 5, 0, 1'b0, 16'h0054};
        run_block(v);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
